// File: rtl/mips_alu_pkg.sv
// Shared encodings for the execute-stage ALU: function codes from the control
// unit and the internal ALU control values they decode to.
package mips_alu_pkg;

  localparam logic [5:0] OP_ADD = 6'h20;
  localparam logic [5:0] OP_SUB = 6'h22;
  localparam logic [5:0] OP_AND = 6'h24;
  localparam logic [5:0] OP_OR  = 6'h25;
  localparam logic [5:0] OP_XOR = 6'h26;
  localparam logic [5:0] OP_NOR = 6'h27;
  localparam logic [5:0] OP_SLT = 6'h2A;

  localparam logic [3:0] CTL_AND = 4'b0000;
  localparam logic [3:0] CTL_OR  = 4'b0001;
  localparam logic [3:0] CTL_ADD = 4'b0010;
  localparam logic [3:0] CTL_XOR = 4'b0011;
  localparam logic [3:0] CTL_SUB = 4'b0110;
  localparam logic [3:0] CTL_SLT = 4'b0111;
  localparam logic [3:0] CTL_NOR = 4'b1100;

endpackage

// File: rtl/mips_alu_unit_adder.sv
// Flag-less modulo-2^WIDTH adder used for the PC-increment and branch-target paths.
module mips_alu_unit_adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/mips_alu_unit.sv
// Execute stage of the single-cycle MIPS core: op decode, ALU, PC/branch adders
// and a small status register of captured flags.
module mips_alu_unit
  import mips_alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int PC_INC = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       alu_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [WIDTH-1:0] pc_in,
  input  logic [WIDTH-1:0] br_off,
  input  logic             flag_en,
  output logic [3:0]       alu_ctl,
  output logic [WIDTH-1:0] alu_res,
  output logic             zero,
  output logic             ovf,
  output logic             cout,
  output logic [WIDTH-1:0] pc_plus4,
  output logic [WIDTH-1:0] br_target,
  output logic             zero_q,
  output logic             ovf_q,
  output logic             cout_q,
  output logic             ovf_sticky
);

  logic [WIDTH:0]   sum_ext;
  logic [WIDTH-1:0] b_eff;
  logic             zero_d, ovf_d, cout_d, ovf_sticky_d, ovf_sticky_q;

  // Unknown function codes fall back to ADD so stray encodings still compute an address.
  function automatic logic [3:0] decode_op(input logic [5:0] op);
    case (op)
      OP_ADD:  return CTL_ADD;
      OP_SUB:  return CTL_SUB;
      OP_SLT:  return CTL_SLT;
      OP_XOR:  return CTL_XOR;
      OP_AND:  return CTL_AND;
      OP_OR:   return CTL_OR;
      OP_NOR:  return CTL_NOR;
      default: return CTL_ADD;
    endcase
  endfunction

  assign alu_ctl = decode_op(alu_op);

  always_comb begin
    sum_ext = '0;
    b_eff   = b;
    alu_res = '0;
    ovf     = 1'b0;
    cout    = 1'b0;
    case (alu_ctl)
      CTL_ADD: begin
        sum_ext = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        alu_res = sum_ext[WIDTH-1:0];
        cout    = sum_ext[WIDTH];
        ovf     = (a[WIDTH-1] == b_eff[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
      end
      CTL_SUB: begin
        b_eff   = ~b;
        sum_ext = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, 1'b1};
        alu_res = sum_ext[WIDTH-1:0];
        cout    = sum_ext[WIDTH];
        ovf     = (a[WIDTH-1] == b_eff[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
      end
      // A true signed compare, not the sign of a-b, so overflowing differences stay correct.
      CTL_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      CTL_AND: alu_res = a & b;
      CTL_OR:  alu_res = a | b;
      CTL_XOR: alu_res = a ^ b;
      CTL_NOR: alu_res = ~(a | b);
      default: alu_res = '0;
    endcase
  end

  assign zero = (alu_res == '0);

  mips_alu_unit_adder #(.WIDTH(WIDTH)) u_pc_adder (
    .a   (pc_in),
    .b   (WIDTH'(PC_INC)),
    .sum (pc_plus4)
  );

  mips_alu_unit_adder #(.WIDTH(WIDTH)) u_br_adder (
    .a   (pc_plus4),
    .b   (br_off),
    .sum (br_target)
  );

  always_comb begin
    zero_d       = zero_q;
    ovf_d        = ovf_q;
    cout_d       = cout_q;
    ovf_sticky_d = ovf_sticky_q;
    if (flag_en) begin
      zero_d       = zero;
      ovf_d        = ovf;
      cout_d       = cout;
      ovf_sticky_d = ovf_sticky_q | ovf;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      zero_q       <= 1'b0;
      ovf_q        <= 1'b0;
      cout_q       <= 1'b0;
      ovf_sticky_q <= 1'b0;
    end else begin
      zero_q       <= zero_d;
      ovf_q        <= ovf_d;
      cout_q       <= cout_d;
      ovf_sticky_q <= ovf_sticky_d;
    end
  end

  assign ovf_sticky = ovf_sticky_q;

endmodule

// File: tb/tb_mips_alu_unit.sv
// Self-checking bench for mips_alu_unit: directed corner cases followed by
// randomized operations checked against an arithmetic reference model.
module tb_mips_alu_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  alu_op;
  logic [31:0] a, b, pc_in, br_off;
  logic        cin, flag_en;
  logic [3:0]  alu_ctl;
  logic [31:0] alu_res, pc_plus4, br_target;
  logic        zero, ovf, cout, zero_q, ovf_q, cout_q, ovf_sticky;

  int n_compared   = 0;
  int n_mismatched = 0;

  // Expected combinational results for the inputs currently applied
  logic [3:0]  e_ctl;
  logic [31:0] e_res, e_pc4, e_br;
  logic        e_zero, e_ovf, e_cout;

  // Expected status register contents
  logic m_zero = 1'b0, m_ovf = 1'b0, m_cout = 1'b0, m_sticky = 1'b0;

  mips_alu_unit dut (
    .clk        (clk),
    .reset      (reset),
    .alu_op     (alu_op),
    .a          (a),
    .b          (b),
    .cin        (cin),
    .pc_in      (pc_in),
    .br_off     (br_off),
    .flag_en    (flag_en),
    .alu_ctl    (alu_ctl),
    .alu_res    (alu_res),
    .zero       (zero),
    .ovf        (ovf),
    .cout       (cout),
    .pc_plus4   (pc_plus4),
    .br_target  (br_target),
    .zero_q     (zero_q),
    .ovf_q      (ovf_q),
    .cout_q     (cout_q),
    .ovf_sticky (ovf_sticky)
  );

  always #5 clk = ~clk;

  // Reference ALU computed from integer arithmetic on 64-bit values
  function automatic void ref_alu(input logic [5:0] op, input logic [31:0] ra, input logic [31:0] rb,
                                  input logic rcin, output logic [3:0] ctl, output logic [31:0] res,
                                  output logic ov, output logic co);
    longint sa, sb, wide;
    longint unsigned ua, ub, uw;
    sa = longint'($signed(ra));
    sb = longint'($signed(rb));
    ua = {32'd0, ra};
    ub = {32'd0, rb};
    ov = 1'b0;
    co = 1'b0;
    case (op)
      6'h22: begin
        ctl  = 4'b0110;
        res  = ra - rb;
        co   = (ra >= rb);
        wide = sa - sb;
        ov   = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
      end
      6'h2A: begin ctl = 4'b0111; res = (sa < sb) ? 32'd1 : 32'd0; end
      6'h26: begin ctl = 4'b0011; res = ra ^ rb; end
      6'h24: begin ctl = 4'b0000; res = ra & rb; end
      6'h25: begin ctl = 4'b0001; res = ra | rb; end
      6'h27: begin ctl = 4'b1100; res = ~(ra | rb); end
      default: begin
        ctl  = 4'b0010;
        uw   = ua + ub + longint'(rcin);
        res  = uw[31:0];
        co   = uw[32];
        wide = sa + sb + longint'(rcin);
        ov   = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
      end
    endcase
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    assert (obs === exp) else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive inputs on the falling edge and compute the model's expectations
  task automatic apply_stimulus(input logic [5:0] op, input logic [31:0] va, input logic [31:0] vb,
                                input logic vcin, input logic [31:0] vpc, input logic [31:0] voff,
                                input logic vfen);
    @(negedge clk);
    alu_op  = op;
    a       = va;
    b       = vb;
    cin     = vcin;
    pc_in   = vpc;
    br_off  = voff;
    flag_en = vfen;
    ref_alu(op, va, vb, vcin, e_ctl, e_res, e_ovf, e_cout);
    e_zero = (e_res == 32'd0);
    e_pc4  = vpc + 32'd4;
    e_br   = e_pc4 + voff;
    #1;
  endtask

  task automatic check_comb(input string tag);
    check_output({tag, ".ctl"},  {28'd0, alu_ctl}, {28'd0, e_ctl});
    check_output({tag, ".res"},  alu_res, e_res);
    check_output({tag, ".zero"}, {31'd0, zero}, {31'd0, e_zero});
    check_output({tag, ".ovf"},  {31'd0, ovf},  {31'd0, e_ovf});
    check_output({tag, ".cout"}, {31'd0, cout}, {31'd0, e_cout});
    check_output({tag, ".pc4"},  pc_plus4, e_pc4);
    check_output({tag, ".br"},   br_target, e_br);
  endtask

  task automatic check_status(input string tag);
    check_output({tag, ".zero_q"}, {31'd0, zero_q},     {31'd0, m_zero});
    check_output({tag, ".ovf_q"},  {31'd0, ovf_q},      {31'd0, m_ovf});
    check_output({tag, ".cout_q"}, {31'd0, cout_q},     {31'd0, m_cout});
    check_output({tag, ".sticky"}, {31'd0, ovf_sticky}, {31'd0, m_sticky});
  endtask

  // Advance one rising edge, update the status model, then sample
  task automatic clock_step(input string tag);
    @(posedge clk);
    if (reset && flag_en) begin
      m_zero   = e_zero;
      m_ovf    = e_ovf;
      m_cout   = e_cout;
      m_sticky = m_sticky | e_ovf;
    end
    #1;
    check_status(tag);
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] corners [4];
    corners[0] = 32'h0000_0000;
    corners[1] = 32'h7FFF_FFFF;
    corners[2] = 32'h8000_0000;
    corners[3] = 32'hFFFF_FFFF;
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 3)];
    return $urandom;
  endfunction

  initial begin
    logic [5:0] ops [7];
    logic [5:0] op;
    ops[0] = 6'h20; ops[1] = 6'h22; ops[2] = 6'h2A; ops[3] = 6'h26;
    ops[4] = 6'h24; ops[5] = 6'h25; ops[6] = 6'h27;

    reset = 1'b0;
    alu_op = 6'h20; a = '0; b = '0; cin = 1'b0; pc_in = '0; br_off = '0; flag_en = 1'b0;
    #1;
    check_status("reset");
    @(negedge clk);
    reset = 1'b1;

    // Directed corner cases
    apply_stimulus(6'h20, 32'h7FFF_FFFF, 32'h1, 1'b0, 32'h0, 32'h0, 1'b0);
    check_comb("add_ovf");
    check_output("add_ovf.res_const", alu_res, 32'h8000_0000);
    apply_stimulus(6'h22, 32'h5, 32'h5, 1'b1, 32'h0, 32'h0, 1'b0);
    check_comb("sub_eq");
    check_output("sub_eq.zero_const", {31'd0, zero}, 32'd1);
    apply_stimulus(6'h22, 32'h8000_0000, 32'h1, 1'b0, 32'h0, 32'h0, 1'b0);
    check_comb("sub_ovf");
    apply_stimulus(6'h2A, 32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0, 32'h0, 1'b0);
    check_comb("slt_neg");
    apply_stimulus(6'h2A, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 32'h0, 32'h0, 1'b0);
    check_comb("slt_min");
    apply_stimulus(6'h2A, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 32'h0, 32'h0, 1'b0);
    check_comb("slt_swap");
    apply_stimulus(6'h26, 32'hF0F0_F0F0, 32'h0000_FFFF, 1'b0, 32'h0, 32'h0, 1'b0);
    check_comb("xor");
    check_output("xor.res_const", alu_res, 32'hF0F0_0F0F);
    apply_stimulus(6'h27, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    check_comb("nor");
    apply_stimulus(6'h3F, 32'h1234_0000, 32'h0000_5678, 1'b1, 32'h0, 32'h0, 1'b0);
    check_comb("op_unknown");
    apply_stimulus(6'h20, 32'h0, 32'h0, 1'b0, 32'hFFFF_FFFC, 32'h0, 1'b0);
    check_comb("pc_wrap");
    apply_stimulus(6'h20, 32'h0, 32'h0, 1'b0, 32'h0000_0100, 32'hFFFF_FFF8, 1'b0);
    check_comb("br_back");
    check_output("br_back.const", br_target, 32'h0000_00FC);

    // Status register: overflow, clean add, hold, then asynchronous clear
    apply_stimulus(6'h20, 32'h7FFF_FFFF, 32'h1, 1'b0, 32'h0, 32'h0, 1'b1);
    clock_step("st_ovf");
    apply_stimulus(6'h20, 32'h1, 32'h1, 1'b0, 32'h0, 32'h0, 1'b1);
    clock_step("st_clean");
    apply_stimulus(6'h22, 32'h5, 32'h5, 1'b0, 32'h0, 32'h0, 1'b0);
    clock_step("st_hold");
    apply_stimulus(6'h22, 32'h5, 32'h5, 1'b0, 32'h0, 32'h0, 1'b1);
    clock_step("st_zero");
    #1;
    reset = 1'b0;
    m_zero = 1'b0; m_ovf = 1'b0; m_cout = 1'b0; m_sticky = 1'b0;
    #1;
    check_status("st_async_clr");
    check_comb("st_comb_in_reset");
    #1;
    reset = 1'b1;

    // Randomized operations
    for (int i = 0; i < 300; i++) begin
      op = ($urandom_range(0, 7) == 7) ? 6'($urandom) : ops[$urandom_range(0, 6)];
      apply_stimulus(op, pick_operand(), pick_operand(), 1'($urandom), $urandom, $urandom,
                     1'($urandom));
      check_comb("rand");
      clock_step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
